regfile_wb_queue: RTL and testbench
===================================

# regfile_wb_queue

Write-back side companion of `regfile`: buffers pending register writes from the execute/memory stages and drains them, one per cycle, into the regfile write port (`wen`/`wadd`/`wdata`). While writes are queued, it forwards the newest pending value for the two read addresses, so readers never see stale data. Writes to `$0` are accepted and dropped, matching the regfile's hard-wired zero.

## Interface
- `DEPTH`, 4: number of queue entries (power of two, 2..16)
- `AW`, 5: register address width
- `DW`, 32: data width
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  producer offers a write
- `in_ready`  out  1  queue can accept a write this cycle
- `in_addr`  in  AW  destination register
- `in_data`  in  DW  write value
- `wb_stall`  in  1  regfile port busy; hold head, no write
- `wen`  out  1  regfile write enable
- `wadd`  out  AW  regfile write address
- `wdata`  out  DW  regfile write data
- `ra1`, `ra2`  in  AW  read addresses being presented to the regfile
- `fwd1_hit`, `fwd2_hit`  out  1  a pending entry matches `ra1`/`ra2`
- `fwd1_data`, `fwd2_data`  out  DW  newest matching pending value (0 when no hit)
- `count`  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Storage: circular buffer with `DEPTH` entries of {addr, data}, plus head pointer, tail pointer and occupancy counter. Pointers wrap modulo `DEPTH`.
- Push: when `in_valid && in_ready` and `in_addr != 0`, write the entry at the tail and advance the tail. When `in_addr == 0`, the handshake completes but nothing is stored and `count` is unchanged.
- `in_ready = (count < DEPTH)`. This is purely a function of registered `count`. There is no push-through when full, even if a pop happens in the same cycle.
- Drain: when `count > 0 && !wb_stall`:
  - `wen` = 1, with `wadd`/`wdata` taken from the head entry.
  - The head pops at the next rising edge.
- When `count == 0` or `wb_stall` = 1: `wen` = 0, and `wadd`/`wdata` are driven as 0.
- Simultaneous push and pop: both happen at the same edge and `count` is unchanged.
- Forwarding (combinational):
  - Scan the occupied entries. The hit for `raX` is the youngest entry (closest to the tail) whose addr == `raX`.
  - The head entry is included, even while it is being written this cycle.
  - `raX == 0` never hits.
  - The incoming `in_*` write of the current cycle is not forwarded.
- Reset (`rst` low, async): head, tail and `count` clear to 0. Entry contents are don't-care but are never forwarded. Any pending writes are lost.

## Timing
- Reset values: `count` = 0, `in_ready` = 1, `wen` = 0, `wadd` = 0, `wdata` = 0, `fwd*_hit` = 0, `fwd*_data` = 0.
- Latency:
  - A write accepted at edge N drives `wen` during cycle N..N+1 if the queue was empty and `wb_stall` = 0.
  - The regfile captures it at edge N+1.
  - Minimum latency is 1 cycle from acceptance to commit.
- Throughput: one push and one pop per cycle. Under sustained `wb_stall` the queue fills after `DEPTH` accepted non-zero writes, and `in_ready` drops the cycle after the `DEPTH`th push.
- `wb_stall` and `ra*` → `wen`/`fwd*` are combinational paths. All other outputs are registered or derived from registered state only.
- Reset asserted mid-drain: `wen` falls immediately (asynchronously), with no partial commit.

## Test plan
- Reset and basic commit:
  - Stimulus: hold `rst`=0 for 2 cycles, then release; push (addr 1, data 4).
  - Response: `wen`=1, `wadd`=1, `wdata`=4 for exactly one cycle, then `count` returns to 0.
- `$0` drop:
  - Stimulus: push (addr 0, data 1).
  - Response: `in_ready` stays 1, `count` stays 0, `wen` never asserts, and `ra1`=0 gives `fwd1_hit`=0.
- Fill under stall:
  - Stimulus: `wb_stall`=1; push (1,0x10), (2,0x20), (3,0x30), (31,0x7).
  - Response: `count`=4 and `in_ready`=0; a fifth offer is not accepted.
  - Continuation: release the stall. Commits appear in order 1,2,3,31 on 4 consecutive cycles.
- Forwarding priority:
  - Stimulus: under stall, push (5,0xA) then (5,0xB); set `ra1`=5, `ra2`=6.
  - Response: `fwd1_hit`=1, `fwd1_data`=0xB, `fwd2_hit`=0.
  - Continuation: after the first pop, `fwd1_data` is still 0xB; after both pops, `fwd1_hit`=0.
- Full with simultaneous push/pop:
  - Stimulus: fill to 4, then release the stall while holding `in_valid`.
  - Response: no push on the pop cycle; `count` goes 4→3; the push is accepted on the next cycle and `count` stays 3.
- Async reset mid-operation:
  - Stimulus: with 3 entries pending, pulse `rst` low between clock edges.
  - Response: `wen`, `count` and `fwd*_hit` drop to 0 immediately, and no further commits occur after release.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Write-back queue ahead of the regfile port: buffers writes, drains one per cycle (>=1 cycle
// accept-to-commit), forwards newest pending values; in_ready drops when full, wb_stall holds the head.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     wb_stall,
  output logic                     wen,
  output logic [AW-1:0]            wadd,
  output logic [DW-1:0]            wdata,
  input  logic [AW-1:0]            ra1,
  input  logic [AW-1:0]            ra2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DW-1:0]            fwd1_data,
  output logic [DW-1:0]            fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] idx;
  logic          push;
  logic          pop;

  // Writes to $0 complete the handshake but never occupy an entry.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign pop      = (count != '0) && !wb_stall;

  assign wen   = pop;
  assign wadd  = pop ? addr_q[head] : '0;
  assign wdata = pop ? data_q[head] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end
  end

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if ((ra1 != '0) && (addr_q[idx] == ra1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[idx];
        end
        if ((ra2 != '0) && (addr_q[idx] == ra2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: reset, commit, $0 drop, fill/drain order,
// forwarding priority, full-with-pop, and async reset mid-drain.
module tb_regfile_wb_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        wb_stall;
  logic        wen;
  logic [4:0]  wadd;
  logic [31:0] wdata;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wb_stall(wb_stall), .wen(wen), .wadd(wadd), .wdata(wdata),
    .ra1(ra1), .ra2(ra2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here,
  // outputs are checked one more time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  logic [4:0]  fa [4];
  logic [31:0] fd [4];

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    wb_stall = 1'b0; ra1 = 5'd1; ra2 = 5'd2;
    fa[0] = 5'd1;  fd[0] = 32'h10;
    fa[1] = 5'd2;  fd[1] = 32'h20;
    fa[2] = 5'd3;  fd[2] = 32'h30;
    fa[3] = 5'd31; fd[3] = 32'h7;

    // Reset values
    #2;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wen", wen, 0);
    chk("rst_wadd", wadd, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_fwd1_hit", fwd1_hit, 0);
    chk("rst_fwd2_hit", fwd2_hit, 0);
    chk("rst_fwd1_data", fwd1_data, 0);
    chk("rst_fwd2_data", fwd2_data, 0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // Basic commit
    push_one(5'd1, 32'd4);
    #1;
    chk("commit_wen", wen, 1);
    chk("commit_wadd", wadd, 1);
    chk("commit_wdata", wdata, 4);
    chk("commit_count", count, 1);
    chk("commit_fwd_head", fwd1_hit, 1);
    chk("commit_fwd_head_data", fwd1_data, 4);
    cyc(); #1;
    chk("commit_done_wen", wen, 0);
    chk("commit_done_count", count, 0);

    // $0 drop
    ra1 = 5'd0;
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'd1;
    #1;
    chk("zero_in_ready", in_ready, 1);
    cyc(); in_valid = 1'b0; #1;
    chk("zero_count", count, 0);
    chk("zero_wen", wen, 0);
    chk("zero_fwd1_hit", fwd1_hit, 0);
    chk("zero_in_ready_after", in_ready, 1);

    // Fill under stall, fifth offer refused, ordered drain
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) push_one(fa[i], fd[i]);
    #1;
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_wen_stalled", wen, 0);
    in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h99;
    cyc(); in_valid = 1'b0; #1;
    chk("fill_fifth_refused", count, 4);
    wb_stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_wen", i), wen, 1);
      chk($sformatf("drain%0d_wadd", i), wadd, fa[i]);
      chk($sformatf("drain%0d_wdata", i), wdata, fd[i]);
      cyc(); #1;
    end
    chk("drain_end_wen", wen, 0);
    chk("drain_end_count", count, 0);

    // Forwarding priority
    wb_stall = 1'b1;
    push_one(5'd5, 32'hA);
    push_one(5'd5, 32'hB);
    ra1 = 5'd5; ra2 = 5'd6;
    #1;
    chk("fwd_hit1", fwd1_hit, 1);
    chk("fwd_data1", fwd1_data, 32'hB);
    chk("fwd_hit2", fwd2_hit, 0);
    chk("fwd_data2", fwd2_data, 0);
    wb_stall = 1'b0;
    #1;
    chk("fwd_pop_wdata", wdata, 32'hA);
    cyc(); #1;
    chk("fwd_after_pop1_hit", fwd1_hit, 1);
    chk("fwd_after_pop1_data", fwd1_data, 32'hB);
    chk("fwd_after_pop1_count", count, 1);
    cyc(); #1;
    chk("fwd_after_pop2_hit", fwd1_hit, 0);
    chk("fwd_after_pop2_data", fwd1_data, 0);
    chk("fwd_after_pop2_count", count, 0);

    // Full with simultaneous push/pop
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) push_one(5'(i + 1), 32'h41 + 32'(i));
    wb_stall = 1'b0;
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h77;
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_wadd", wadd, 1);
    cyc(); #1;
    chk("full_pop_count", count, 3);
    chk("full_pop_in_ready", in_ready, 1);
    chk("full_pop_wadd", wadd, 2);
    cyc(); in_valid = 1'b0; #1;
    chk("full_pushpop_count", count, 3);
    chk("full_d3_wadd", wadd, 3);
    cyc(); #1;
    chk("full_d4_wadd", wadd, 4);
    cyc(); #1;
    chk("full_d7_wadd", wadd, 7);
    chk("full_d7_wdata", wdata, 32'h77);
    cyc(); #1;
    chk("full_end_count", count, 0);

    // Async reset mid-drain
    wb_stall = 1'b1;
    push_one(5'd1, 32'h51);
    push_one(5'd2, 32'h52);
    push_one(5'd3, 32'h53);
    ra1 = 5'd2;
    wb_stall = 1'b0;
    #1;
    chk("arst_pre_wen", wen, 1);
    chk("arst_pre_count", count, 3);
    chk("arst_pre_fwd", fwd1_hit, 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_wen", wen, 0);
    chk("arst_count", count, 0);
    chk("arst_fwd1_hit", fwd1_hit, 0);
    chk("arst_in_ready", in_ready, 1);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk($sformatf("arst_post%0d_wen", i), wen, 0);
    end
    chk("arst_post_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
